// File: rtl/rotary_encoder_if.sv
// Encoder pin / level bundle shared between the quadrature front end and its user.
// slave = the encoder block, master = whatever owns the pins and consumes the level.
interface rotary_encoder_if;
  logic       enc_a;
  logic       enc_b;
  logic [7:0] value;
  logic       step_up;
  logic       step_down;
  logic       ready;

  modport master (
    output enc_a, enc_b,
    input  value, step_up, step_down, ready
  );

  modport slave (
    input  enc_a, enc_b,
    output value, step_up, step_down, ready
  );
endinterface

// File: rtl/rotary_encoder.sv
// Quadrature rotary-encoder front end: per-channel sync + debounce, x1 decode on
// debounced A rising edges, wrap/saturating 8-bit level with step pulses.

module rotary_encoder_debounce #(
  parameter int CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db
);
  localparam logic [15:0] LAST = 16'(CYCLES - 1);

  logic        s1, s2;
  logic [15:0] cnt;

  // Counter only runs while the synchronised level disagrees with db;
  // any return to the old level restarts the qualification window.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      db  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end
endmodule

module rotary_encoder #(
  parameter int DEBOUNCE_CYCLES = 255,
  parameter int STEP            = 1,
  parameter int SATURATE        = 0,
  parameter int INIT_VALUE      = 0
) (
  input  logic             clk,
  input  logic             reset,
  rotary_encoder_if.slave  enc
);
  localparam int          NUM_CH  = 2;
  localparam logic [16:0] SU_LAST = 17'(DEBOUNCE_CYCLES + 2);
  localparam logic [7:0]  STEP8   = 8'(STEP);
  localparam logic [7:0]  INIT8   = 8'(INIT_VALUE);

  logic [NUM_CH-1:0] pins;
  logic [NUM_CH-1:0] db;
  logic              a_prev;
  logic              rise;
  logic [16:0]       su_cnt;
  logic              ready;
  logic [7:0]        level;
  logic              up_pulse, down_pulse;
  logic [8:0]        sum_up;
  logic [7:0]        next_up, next_down;

  assign pins = {enc.enc_b, enc.enc_a};

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    rotary_encoder_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (pins[ch]),
      .db    (db[ch])
    );
  end

  // Settle window: lets debounced copies absorb pins resting high at power-up
  // before any edge is allowed to count.
  always_ff @(posedge clk) begin
    if (reset) begin
      su_cnt <= '0;
      ready  <= 1'b0;
    end else if (!ready) begin
      su_cnt <= su_cnt + 17'd1;
      if (su_cnt == SU_LAST) ready <= 1'b1;
    end
  end

  assign rise = db[0] & ~a_prev & ready;

  always_comb begin
    sum_up    = {1'b0, level} + {1'b0, STEP8};
    next_up   = sum_up[7:0];
    next_down = level - STEP8;
    if (SATURATE != 0) begin
      if (sum_up[8]) next_up = 8'hFF;
      if (level < STEP8) next_down = 8'h00;
    end
  end

  // B's debounced level in the rise cycle picks direction; a clamped step still pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_prev     <= 1'b0;
      level      <= INIT8;
      up_pulse   <= 1'b0;
      down_pulse <= 1'b0;
    end else begin
      a_prev     <= db[0];
      up_pulse   <= rise & ~db[1];
      down_pulse <= rise &  db[1];
      if (rise) level <= db[1] ? next_down : next_up;
    end
  end

  assign enc.value     = level;
  assign enc.step_up   = up_pulse;
  assign enc.step_down = down_pulse;
  assign enc.ready     = ready;
endmodule

// File: tb/tb_rotary_encoder.sv
// Scoreboarded bench: four encoder instances (D=4) covering wrap, saturate and
// start-up behaviour; stimulus queues expected pulses, a negedge monitor retires them.
module tb_rotary_encoder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst   [4];
  logic       a_drv [4];
  logic       b_drv [4];
  logic [7:0] val_o [4];
  logic       up_o  [4];
  logic       dn_o  [4];
  logic       rdy_o [4];

  int cyc = 0;
  int chk_cnt = 0;
  int pass_cnt = 0;

  typedef struct {
    int   idx;
    logic up;
    int   val;
    int   cyc;
  } exp_t;
  exp_t q[$];

  rotary_encoder_if eif0 ();
  rotary_encoder_if eif1 ();
  rotary_encoder_if eif2 ();
  rotary_encoder_if eif3 ();

  assign eif0.enc_a = a_drv[0];  assign eif0.enc_b = b_drv[0];
  assign eif1.enc_a = a_drv[1];  assign eif1.enc_b = b_drv[1];
  assign eif2.enc_a = a_drv[2];  assign eif2.enc_b = b_drv[2];
  assign eif3.enc_a = a_drv[3];  assign eif3.enc_b = b_drv[3];

  assign val_o[0] = eif0.value;  assign up_o[0] = eif0.step_up;
  assign dn_o[0]  = eif0.step_down; assign rdy_o[0] = eif0.ready;
  assign val_o[1] = eif1.value;  assign up_o[1] = eif1.step_up;
  assign dn_o[1]  = eif1.step_down; assign rdy_o[1] = eif1.ready;
  assign val_o[2] = eif2.value;  assign up_o[2] = eif2.step_up;
  assign dn_o[2]  = eif2.step_down; assign rdy_o[2] = eif2.ready;
  assign val_o[3] = eif3.value;  assign up_o[3] = eif3.step_up;
  assign dn_o[3]  = eif3.step_down; assign rdy_o[3] = eif3.ready;

  rotary_encoder #(.DEBOUNCE_CYCLES(4), .STEP(1),  .SATURATE(0), .INIT_VALUE(100)) u0 (
    .clk(clk), .reset(rst[0]), .enc(eif0));
  rotary_encoder #(.DEBOUNCE_CYCLES(4), .STEP(16), .SATURATE(0), .INIT_VALUE(8))   u1 (
    .clk(clk), .reset(rst[1]), .enc(eif1));
  rotary_encoder #(.DEBOUNCE_CYCLES(4), .STEP(10), .SATURATE(1), .INIT_VALUE(250)) u2 (
    .clk(clk), .reset(rst[2]), .enc(eif2));
  rotary_encoder #(.DEBOUNCE_CYCLES(4), .STEP(10), .SATURATE(1), .INIT_VALUE(5))   u3 (
    .clk(clk), .reset(rst[3]), .enc(eif3));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    chk_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full detent: settle B, raise A (pulse expected D+3 edges later), drop A.
  task automatic detent(input int idx, input logic b, input logic up, input int v);
    b_drv[idx] = b;
    step(10);
    a_drv[idx] = 1'b1;
    q.push_back('{idx: idx, up: up, val: v, cyc: cyc + 7});
    step(12);
    check($sformatf("value_after_detent_u%0d", idx), int'(val_o[idx]), v);
    a_drv[idx] = 1'b0;
    step(12);
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (up_o[i] && dn_o[i]) begin
        check($sformatf("both_pulses_u%0d", i), 1, 0);
      end else if (up_o[i] || dn_o[i]) begin
        if (q.size() == 0) begin
          check($sformatf("unexpected_pulse_u%0d_val", i), int'(val_o[i]), -1);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("pulse_instance", i, e.idx);
          check("pulse_direction_up", int'(up_o[i]), int'(e.up));
          check("pulse_value", int'(val_o[i]), e.val);
          check("pulse_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int init_v [4];
    int r;
    init_v = '{100, 8, 250, 5};
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1; a_drv[i] = 1'b0; b_drv[i] = 1'b0;
    end
    step(3);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset_value_u%0d", i), int'(val_o[i]), init_v[i]);
      check($sformatf("reset_ready_u%0d", i), int'(rdy_o[i]), 0);
      check($sformatf("reset_pulses_u%0d", i), int'(up_o[i] | dn_o[i]), 0);
    end

    for (int i = 0; i < 4; i++) rst[i] = 1'b0;
    step(6);
    for (int i = 0; i < 4; i++) check($sformatf("ready_edge6_u%0d", i), int'(rdy_o[i]), 0);
    step(1);
    for (int i = 0; i < 4; i++) check($sformatf("ready_edge7_u%0d", i), int'(rdy_o[i]), 1);
    step(3);

    // Basic increment, then holding A shows no further change
    detent(0, 1'b0, 1'b1, 101);
    check("hold_no_change_u0", int'(val_o[0]), 101);

    // 3-cycle glitch is rejected; 4-cycle pulse qualifies
    a_drv[0] = 1'b1; step(3); a_drv[0] = 1'b0; step(12);
    check("glitch_rejected_u0", int'(val_o[0]), 101);
    a_drv[0] = 1'b1;
    q.push_back('{idx: 0, up: 1'b1, val: 102, cyc: cyc + 7});
    step(4); a_drv[0] = 1'b0; step(12);
    check("short_valid_pulse_u0", int'(val_o[0]), 102);

    // Wrap: 8 - 16 = 248, 248 + 16 = 8
    detent(1, 1'b1, 1'b0, 248);
    detent(1, 1'b0, 1'b1, 8);

    // Saturate high: three clamped up steps still pulse
    detent(2, 1'b0, 1'b1, 255);
    detent(2, 1'b0, 1'b1, 255);
    detent(2, 1'b0, 1'b1, 255);

    // Saturate low
    detent(3, 1'b1, 1'b0, 0);

    // A held high through reset release: no step
    rst[0] = 1'b1; a_drv[0] = 1'b1;
    step(3);
    rst[0] = 1'b0;
    step(30);
    check("held_high_value_u0", int'(val_o[0]), 100);
    check("held_high_ready_u0", int'(rdy_o[0]), 1);
    a_drv[0] = 1'b0;
    step(12);
    detent(0, 1'b0, 1'b1, 101);

    // Reset mid-debounce aborts the pending step
    a_drv[0] = 1'b1;
    step(4);
    rst[0] = 1'b1;
    step(1);
    check("mid_reset_value_u0", int'(val_o[0]), 100);
    check("mid_reset_ready_u0", int'(rdy_o[0]), 0);
    a_drv[0] = 1'b0;
    rst[0] = 1'b0;
    step(20);
    check("post_reset_value_u0", int'(val_o[0]), 100);
    detent(0, 1'b0, 1'b1, 101);

    step(5);
    r = q.size();
    check("scoreboard_drained", r, 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
